// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if: board-side bundle for the ALU sequencer.
//   Inputs to the controller : left_sw, right_sw, step, auto, alu_y
//   Outputs from controller  : left, right, mode, done, g_to_a, an, dp
// master = board / stimulus side, slave = controller side.
interface alu_seq_ctrl_if;
    logic [2:0] left_sw;
    logic [2:0] right_sw;
    logic       step;
    logic       auto;
    logic [3:0] alu_y;
    logic [2:0] left;
    logic [2:0] right;
    logic [1:0] mode;
    logic       done;
    logic [6:0] g_to_a;
    logic [3:0] an;
    logic       dp;

    modport master (
        output left_sw, right_sw, step, auto, alu_y,
        input  left, right, mode, done, g_to_a, an, dp
    );

    modport slave (
        input  left_sw, right_sw, step, auto, alu_y,
        output left, right, mode, done, g_to_a, an, dp
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequencer and display controller for the 3-bit ALU core.
// Latches operands from switches, steps mode 0..3 by button or auto timer,
// and scans a 4-digit active-low seven-segment display.
//   clk  : system clock
//   clr  : synchronous active-high reset
//   bus  : alu_seq_ctrl_if.slave (switches, button, auto, alu_y in;
//          left/right/mode/done and display out)
module alu_seq_ctrl #(
    parameter int unsigned SCAN_W     = 18,
    parameter int unsigned AUTO_TICKS = 50_000_000
) (
    input  logic          clk,
    input  logic          clr,
    alu_seq_ctrl_if.slave bus
);

    localparam int unsigned TickW = (AUTO_TICKS > 2) ? $clog2(AUTO_TICKS) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(AUTO_TICKS - 1);

    typedef enum logic [1:0] {StIdle, StLatch, StShow, StAdvance} state_e;

    state_e            state_q, state_d;
    logic [2:0]        sync_q;
    logic [2:0]        left_q, left_d;
    logic [2:0]        right_q, right_d;
    logic [1:0]        mode_q, mode_d;
    logic              done_q, done_d;
    logic [TickW-1:0]  tick_q, tick_d;
    logic [SCAN_W-1:0] scan_q;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;

    logic              step_pulse;
    logic              auto_hit;
    logic [1:0]        sel;
    logic [3:0]        digit;

    // sync_q[0] is the first stage; rising edge seen between stages 1 and 2.
    assign step_pulse = sync_q[1] & ~sync_q[2];
    assign auto_hit   = bus.auto && (tick_q == TickLast);
    assign sel        = scan_q[SCAN_W-1 -: 2];

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        left_d  = left_q;
        right_d = right_q;
        mode_d  = mode_q;
        tick_d  = tick_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                mode_d = 2'd0;
                if (step_pulse) begin
                    state_d = StLatch;
                end
            end
            StLatch: begin
                left_d  = bus.left_sw;
                right_d = bus.right_sw;
                mode_d  = 2'd0;
                tick_d  = '0;
                state_d = StShow;
            end
            StShow: begin
                if (bus.auto) begin
                    tick_d = tick_q + 1'b1;
                end
                // Button and timer in the same cycle still give a single advance.
                if (step_pulse || auto_hit) begin
                    state_d = StAdvance;
                end
            end
            StAdvance: begin
                tick_d = '0;
                if (mode_q == 2'd3) begin
                    mode_d  = 2'd0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    mode_d  = mode_q + 2'd1;
                    state_d = StShow;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Display digit mux and registered-output next values.
    always_comb begin
        digit = 4'h0;
        an_d  = 4'b1111;
        unique case (sel)
            2'd0: begin an_d = 4'b1110; digit = bus.alu_y;           end
            2'd1: begin an_d = 4'b1101; digit = {1'b0, right_q};     end
            2'd2: begin an_d = 4'b1011; digit = {1'b0, left_q};      end
            default: begin an_d = 4'b0111; digit = {2'b00, mode_q};  end
        endcase
        seg_d = hex7(digit);
        if (state_q == StIdle) begin
            an_d  = 4'b1111;
            seg_d = 7'b1111111;
        end
        dp_d = ~((state_q == StShow) && bus.auto && (sel == 2'd0));
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sync_q  <= '0;
            left_q  <= '0;
            right_q <= '0;
            mode_q  <= '0;
            done_q  <= 1'b0;
            tick_q  <= '0;
            scan_q  <= '0;
            an_q    <= 4'b1111;
            seg_q   <= 7'b1111111;
            dp_q    <= 1'b1;
        end else begin
            sync_q  <= {sync_q[1:0], bus.step};
            left_q  <= left_d;
            right_q <= right_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            tick_q  <= tick_d;
            scan_q  <= scan_q + 1'b1;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign bus.left   = left_q;
    assign bus.right  = right_q;
    assign bus.mode   = mode_q;
    assign bus.done   = done_q;
    assign bus.an     = an_q;
    assign bus.g_to_a = seg_q;
    assign bus.dp     = dp_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: self-checking bench for alu_seq_ctrl with SCAN_W=4, AUTO_TICKS=4.
module tb_alu_seq_ctrl;

    localparam int unsigned ScanW     = 4;
    localparam int unsigned AutoTicks = 4;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    alu_seq_ctrl_if bus ();

    alu_seq_ctrl #(
        .SCAN_W    (ScanW),
        .AUTO_TICKS(AutoTicks)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Edges since the last reset edge; the scan counter should equal this.
    int unsigned cyc;
    always @(posedge clk) begin
        if (clr) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct {
        logic [3:0] y;
        logic [6:0] seg;
    } hex_vec_t;
    hex_vec_t hv[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Digit select that the currently visible registered outputs reflect.
    function automatic int sel_prev();
        return int'(((cyc - 1) >> (ScanW - 2)) % 4);
    endfunction

    task automatic do_reset();
        clr = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b0;
    endtask

    // One-cycle button press; returns 4 negedges later, when its effect is visible.
    task automatic press();
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] dig[4];
        logic [3:0] exp_an;
        int         s;
        bit         show;
        bit         found;
        bit         running;
        logic [1:0] mm;
        logic [2:0] lm, rm;
        bit         exp_done;

        hv[0]  = '{4'h0, 7'b1000000}; hv[1]  = '{4'h1, 7'b1111001};
        hv[2]  = '{4'h2, 7'b0100100}; hv[3]  = '{4'h3, 7'b0110000};
        hv[4]  = '{4'h4, 7'b0011001}; hv[5]  = '{4'h5, 7'b0010010};
        hv[6]  = '{4'h6, 7'b0000010}; hv[7]  = '{4'h7, 7'b1111000};
        hv[8]  = '{4'h8, 7'b0000000}; hv[9]  = '{4'h9, 7'b0010000};
        hv[10] = '{4'hA, 7'b0001000}; hv[11] = '{4'hB, 7'b0000011};
        hv[12] = '{4'hC, 7'b1000110}; hv[13] = '{4'hD, 7'b0100001};
        hv[14] = '{4'hE, 7'b0000110}; hv[15] = '{4'hF, 7'b0001110};

        bus.step = 1'b0; bus.auto = 1'b0;
        bus.left_sw = 3'd0; bus.right_sw = 3'd0; bus.alu_y = 4'd0;

        // Power-on reset values.
        @(negedge clk);
        check("rst_left", 32'(bus.left), 0);
        check("rst_right", 32'(bus.right), 0);
        check("rst_mode", 32'(bus.mode), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_an", 32'(bus.an), 32'hF);
        check("rst_seg", 32'(bus.g_to_a), 32'h7F);
        check("rst_dp", 32'(bus.dp), 1);
        @(negedge clk);
        clr = 1'b0;

        // Manual sweep.
        bus.left_sw = 3'd7; bus.right_sw = 3'd3;
        press();
        check("man_left", 32'(bus.left), 7);
        check("man_right", 32'(bus.right), 3);
        check("man_mode0", 32'(bus.mode), 0);
        bus.left_sw = 3'd0; bus.right_sw = 3'd0;
        for (int m = 1; m <= 3; m++) begin
            press();
            check("man_mode", 32'(bus.mode), 32'(m));
            check("man_left_hold", 32'(bus.left), 7);
        end
        press();
        check("man_done", 32'(bus.done), 1);
        check("man_wrap_mode", 32'(bus.mode), 0);
        @(negedge clk);
        check("man_done_once", 32'(bus.done), 0);
        check("man_idle_an", 32'(bus.an), 32'hF);

        // Display scan with mode=3, left=7, right=3, alu_y=A.
        do_reset();
        bus.left_sw = 3'd7; bus.right_sw = 3'd3; bus.alu_y = 4'hA;
        repeat (4) press();
        check("scan_mode", 32'(bus.mode), 3);
        dig[0] = 4'hA; dig[1] = 4'h3; dig[2] = 4'h7; dig[3] = 4'h3;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            s = sel_prev();
            exp_an = ~(4'b0001 << s);
            check("scan_an", 32'(bus.an), 32'(exp_an));
            check("scan_seg", 32'(bus.g_to_a), 32'(hv[dig[s]].seg));
            check("scan_dp", 32'(bus.dp), 1);
        end

        // Hex decode table through the alu_y digit.
        for (int i = 0; i < 16; i++) begin
            bus.alu_y = hv[i].y;
            found = 1'b0;
            for (int k = 0; k < 16 && !found; k++) begin
                @(negedge clk);
                if (sel_prev() == 0) begin
                    found = 1'b1;
                    check("hex_seg", 32'(bus.g_to_a), 32'(hv[i].seg));
                    check("hex_an", 32'(bus.an), 32'hE);
                end
            end
            if (!found) check("hex_found", 0, 1);
        end

        // Reset mid-SHOW with mode=2.
        do_reset();
        bus.left_sw = 3'd5; bus.right_sw = 3'd6;
        repeat (3) press();
        check("pre_rst_mode", 32'(bus.mode), 2);
        clr = 1'b1;
        @(negedge clk);
        check("mid_rst_left", 32'(bus.left), 0);
        check("mid_rst_right", 32'(bus.right), 0);
        check("mid_rst_mode", 32'(bus.mode), 0);
        check("mid_rst_an", 32'(bus.an), 32'hF);
        check("mid_rst_seg", 32'(bus.g_to_a), 32'h7F);
        check("mid_rst_dp", 32'(bus.dp), 1);
        check("mid_rst_done", 32'(bus.done), 0);
        @(negedge clk);
        clr = 1'b0;
        repeat (10) @(negedge clk);
        check("post_rst_quiet_left", 32'(bus.left), 0);
        check("post_rst_quiet_an", 32'(bus.an), 32'hF);

        // Auto advance: AutoTicks SHOW cycles plus one ADVANCE cycle per mode.
        bus.auto = 1'b1;
        bus.left_sw = 3'd2; bus.right_sw = 3'd1;
        press();
        for (int t = 0; t <= 21; t++) begin
            if (t > 0) @(negedge clk);
            check("auto_mode", 32'(bus.mode), (t < 20) ? 32'(t / 5) : 0);
            check("auto_done", 32'(bus.done), (t == 20) ? 1 : 0);
            s = t - 1;
            show = (s >= 0) && (s <= 18) && ((s % 5) != 4);
            check("auto_dp", 32'(bus.dp), (show && sel_prev() == 0) ? 0 : 1);
        end

        // Auto disabled mid-SHOW freezes the tick count.
        press();
        repeat (2) @(negedge clk);
        bus.auto = 1'b0;
        repeat (10) @(negedge clk);
        check("freeze_mode", 32'(bus.mode), 0);
        bus.auto = 1'b1;
        @(negedge clk);
        check("freeze_t13", 32'(bus.mode), 0);
        @(negedge clk);
        check("freeze_t14", 32'(bus.mode), 0);
        @(negedge clk);
        check("freeze_t15", 32'(bus.mode), 1);
        do_reset();

        // Button pulse coinciding with the last tick: a single advance.
        press();
        @(negedge clk);
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
        for (int t = 3; t <= 11; t++) begin
            @(negedge clk);
            check("simul_mode", 32'(bus.mode), (t < 5) ? 0 : (t < 10) ? 1 : 2);
        end
        bus.auto = 1'b0;
        do_reset();

        // Held button gives one advance.
        press();
        bus.step = 1'b1;
        repeat (20) @(negedge clk);
        check("hold_mode", 32'(bus.mode), 1);
        bus.step = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_mode_after", 32'(bus.mode), 1);

        // Button held through reset: one fresh pulse after release.
        bus.step = 1'b1;
        clr = 1'b1;
        repeat (2) @(negedge clk);
        bus.left_sw = 3'd6;
        clr = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_clr_not_yet", 32'(bus.left), 0);
        @(negedge clk);
        check("hold_clr_left", 32'(bus.left), 6);
        check("hold_clr_mode", 32'(bus.mode), 0);
        repeat (10) @(negedge clk);
        check("hold_clr_single", 32'(bus.mode), 0);
        bus.step = 1'b0;
        @(negedge clk);

        // Randomized manual runs against a transaction-level model.
        do_reset();
        running = 1'b0; mm = 2'd0; lm = 3'd0; rm = 3'd0;
        for (int it = 0; it < 40; it++) begin
            bus.left_sw  = 3'($urandom);
            bus.right_sw = 3'($urandom);
            bus.alu_y    = 4'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            exp_done = 1'b0;
            if (!running) begin
                running = 1'b1; mm = 2'd0; lm = bus.left_sw; rm = bus.right_sw;
            end else if (mm == 2'd3) begin
                running = 1'b0; mm = 2'd0; exp_done = 1'b1;
            end else begin
                mm = mm + 2'd1;
            end
            press();
            check("rnd_left", 32'(bus.left), 32'(lm));
            check("rnd_right", 32'(bus.right), 32'(rm));
            check("rnd_mode", 32'(bus.mode), 32'(mm));
            check("rnd_done", 32'(bus.done), 32'(exp_done));
            check("rnd_dp", 32'(bus.dp), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Sequencer and display controller for the 3-bit ALU datapath (`ALU3_h7seg` core, operands `left`/`right`, operation `mode`). It latches operands from the switches and steps `mode` through 0..3, either on a button or from an auto-advance timer. It also time-multiplexes a 4-digit active-low seven-segment display showing mode, left, right and the ALU result. It sits between the board I/O (switches, button, display) and the combinational ALU core.

## Interface

Parameters:
- `SCAN_W`, 18: width of the display scan counter. Each digit is active for 2^(SCAN_W-2) cycles.
- `AUTO_TICKS`, 50_000_000: number of cycles spent in SHOW before an automatic advance. Minimum value is 2.

Ports:
- `clk`  in  1  system clock. One clock domain.
- `clr`  in  1  synchronous, active-high reset.
- `left_sw`  in  3  operand A from switches.
- `right_sw`  in  3  operand B from switches.
- `step`  in  1  step button, asynchronous level. Synchronized internally.
- `auto`  in  1  auto-advance enable, static level.
- `alu_y`  in  4  result returned by the ALU core for the current `left`/`right`/`mode`.
- `left`  out  3  registered operand A to the ALU.
- `right`  out  3  registered operand B to the ALU.
- `mode`  out  2  registered ALU operation select.
- `done`  out  1  one-cycle pulse when the sequence wraps from mode 3.
- `g_to_a`  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- `an`  out  4  digit enables, active-low, registered. an[3] is the leftmost digit.
- `dp`  out  1  decimal point, active-low, registered.

## Operation

- **Step synchronizer:** `step` passes through 3 flops, q0→q1→q2. `step_pulse = q1 & ~q2`.
  - This gives exactly one pulse per rising edge of `step`, however long it is held.
  - `clr` clears q0..q2.
- **State machine:** states are IDLE, LATCH, SHOW, ADVANCE.
  - **IDLE:** waits for `step_pulse`, then goes to LATCH. `left`/`right` hold their last values. `mode` = 0.
  - **LATCH** (1 cycle): `left<=left_sw`, `right<=right_sw`, `mode<=0`, tick counter cleared. Next state is SHOW.
  - **SHOW:** tick counter increments each cycle while `auto`=1 and holds while `auto`=0. Go to ADVANCE on `step_pulse`, or on `auto && tick==AUTO_TICKS-1`. If both occur in the same cycle, only one advance happens.
  - **ADVANCE** (1 cycle), tick counter cleared:
    - If `mode`==3: `mode<=0`, `done<=1` for this one cycle, next state IDLE.
    - Otherwise: `mode<=mode+1`, next state SHOW.
  - A `step_pulse` arriving in LATCH or ADVANCE is dropped.
- **Operands during a run:** `left_sw`/`right_sw` are sampled only in LATCH. Switch changes during a run have no effect.
- **Display:**
  - Scan counter is free-running (increments every cycle, wraps). Digit select = cnt[SCAN_W-1:SCAN_W-2].
    - Select 0: `an`=1110, shows hex `alu_y`.
    - Select 1: `an`=1101, shows `right`.
    - Select 2: `an`=1011, shows `left`.
    - Select 3: `an`=0111, shows `mode`.
  - Hex-to-segment values (active-low {g..a}):
    - 0→1000000, 1→1111001, 2→0100100, 3→0110000
    - 4→0011001, 5→0010010, 6→0000010, 7→1111000
    - 8→0000000, 9→0010000, A→0001000, b→0000011
    - C→1000110, d→0100001, E→0000110, F→0001110
  - In IDLE, `an`=1111 (blank).
  - `dp`=0 only when state is SHOW, `auto`=1 and digit select = 0. Otherwise `dp`=1.
- **Reset values** (applied at the first `clk` edge with `clr`=1, from any state, including mid-run):
  - State IDLE; `left`=0, `right`=0, `mode`=0, `done`=0.
  - `an`=1111, `g_to_a`=1111111, `dp`=1.
  - Scan counter, tick counter and synchronizer all 0.
  - If `step` is held through `clr`, one fresh `step_pulse` occurs 2 cycles after `clr` deasserts.

## Timing

- **Step latency:** with `step` sampled high at edge k, `step_pulse` is high during cycle k+1..k+2.
  - At edge k+2: IDLE→LATCH.
  - At edge k+3: operands valid, state SHOW.
- **Manual advance:** `mode` updates 2 edges after the edge at which `step_pulse` is seen (SHOW→ADVANCE→SHOW).
- **Auto advance period:** AUTO_TICKS+1 cycles per mode (AUTO_TICKS cycles in SHOW plus 1 in ADVANCE). The first advance comes AUTO_TICKS+1 cycles after LATCH.
- **`done`:** high for exactly the cycle following ADVANCE from mode 3. `mode` reads 0 in the same cycle.
- **Display outputs:** registered, 1 cycle after the scan counter / `alu_y` / state they reflect.
- **`alu_y`:** assumed combinational from `left`/`right`/`mode` and settled within one cycle.

## Test plan

- **Reset:** hold `clr` for 2 cycles mid-SHOW with `mode`=2 → next edge gives `left`=0, `right`=0, `mode`=0, `an`=1111, `g_to_a`=1111111, `dp`=1, `done`=0. No activity follows until a new step.
- **Manual sweep:** `left_sw`=7, `right_sw`=3, pulse `step` → `left`=7, `right`=3, `mode`=0. Three more steps → `mode` 1, 2, 3. Fourth step → `done` pulses once, `mode`=0, `an`=1111.
- **Auto:** AUTO_TICKS=4, `auto`=1 after LATCH → `mode` changes every 5 cycles (0→1→2→3), then `done`, then IDLE. Setting `auto`=0 mid-SHOW freezes the tick count.
- **Display scan:** SCAN_W=4, `mode`=3, `left`=7, `right`=3, `alu_y`=A. Each digit is held 4 cycles with `an` sequence 1110, 1101, 1011, 0111, and `g_to_a` sequence 0001000, 0110000, 1111000, 0110000 respectively. With `auto`=1, `dp`=0 only on the 1110 digit.
- **Simultaneous events:** AUTO_TICKS=4, `step` rising so that `step_pulse` coincides with tick==3 → `mode` increments by exactly 1.
- **Button hold:** `step` held high for 20 cycles in SHOW → exactly one advance. Holding `step` through `clr` → one advance 2 cycles after `clr` falls.
